// File: rtl/io_keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
//   kp_state_t : scanner FSM states
//   COL_INIT   : column drive pattern after reset (column 0 low)
//   onehot_low : decodes a 4-bit active-low line group into {valid, index};
//                valid only when exactly one line is low
package io_keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      PRESS_DB,
      HELD
   } kp_state_t;

   localparam logic [3:0] COL_INIT = 4'b1110;

   typedef struct packed {
      logic       valid;
      logic [1:0] idx;
   } onehot_t;

   function automatic onehot_t onehot_low(input logic [3:0] lines);
      onehot_t r;
      r.valid = 1'b1;
      r.idx   = 2'd0;
      case (lines)
         4'b1110: r.idx = 2'd0;
         4'b1101: r.idx = 2'd1;
         4'b1011: r.idx = 2'd2;
         4'b0111: r.idx = 2'd3;
         default: r.valid = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/keypad_tick.sv
// Column dwell prescaler: counts 0..DIV-1 and wraps.
//   clk  : system clock
//   rst  : asynchronous active-low reset (counter to 0)
//   tick : high on the last cycle of every dwell (count == DIV-1)
module keypad_tick #(
   parameter int unsigned DIV = 1000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + W'(1);
      end
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/io_keypad.sv
// 4x4 passive key matrix scanner/decoder with a one-deep valid/ready output.
//   clk         : system clock
//   rst         : asynchronous active-low reset
//   i_row       : row lines, active-low, asynchronous (2-flop synchronized)
//   o_col       : column drive, active-low, exactly one bit low
//   o_key       : row*4 + col of the buffered key, stable while o_key_valid
//   o_key_valid : buffered key available
//   i_key_ready : consumer takes o_key when high with o_key_valid
//   o_pressed   : a debounced key is currently held
//   o_overrun   : one-cycle pulse, press accepted while buffer full (dropped)
module io_keypad
   import io_keypad_pkg::*;
#(
   parameter int unsigned DIV      = 1000,
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] i_row,
   output logic [3:0] o_col,
   output logic [3:0] o_key,
   output logic       o_key_valid,
   input  logic       i_key_ready,
   output logic       o_pressed,
   output logic       o_overrun
);

   localparam logic [3:0] DB_LAST = 4'(DEBOUNCE);

   logic [3:0] row_meta, row_sync;
   logic       tick;

   kp_state_t  state, state_nxt;
   logic [3:0] col, col_nxt;
   logic [3:0] lat_row, lat_row_nxt;
   logic [3:0] code, code_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [3:0] cnt_inc;
   logic [3:0] col_rot;
   logic       accept;
   onehot_t    row_hit, col_hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_meta <= '1;
         row_sync <= '1;
      end else begin
         row_meta <= i_row;
         row_sync <= row_meta;
      end
   end

   keypad_tick #(.DIV(DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= SCAN;
         col     <= COL_INIT;
         lat_row <= '1;
         code    <= '0;
         cnt     <= '0;
      end else begin
         state   <= state_nxt;
         col     <= col_nxt;
         lat_row <= lat_row_nxt;
         code    <= code_nxt;
         cnt     <= cnt_nxt;
      end
   end

   // cnt is shared: press-confirm count in PRESS_DB, release count in HELD.
   always_comb begin
      state_nxt   = state;
      col_nxt     = col;
      lat_row_nxt = lat_row;
      code_nxt    = code;
      cnt_nxt     = cnt;
      accept      = 1'b0;
      row_hit     = onehot_low(row_sync);
      col_hit     = onehot_low(col);
      cnt_inc     = cnt + 4'd1;
      col_rot     = {col[2:0], col[3]};

      if (tick) begin
         case (state)
            SCAN: begin
               if (row_hit.valid && col_hit.valid) begin
                  state_nxt   = PRESS_DB;
                  lat_row_nxt = row_sync;
                  code_nxt    = {row_hit.idx, col_hit.idx};
                  cnt_nxt     = 4'd1;
               end else begin
                  col_nxt = col_rot;
               end
            end
            PRESS_DB: begin
               if (row_sync == lat_row) begin
                  if (cnt_inc == DB_LAST) begin
                     accept    = 1'b1;
                     state_nxt = HELD;
                     cnt_nxt   = '0;
                  end else begin
                     cnt_nxt = cnt_inc;
                  end
               end else begin
                  state_nxt = SCAN;
                  col_nxt   = col_rot;
               end
            end
            HELD: begin
               // Only all-high counts toward release, so a second key is ignored.
               if (row_sync == 4'b1111) begin
                  if (cnt_inc == DB_LAST) begin
                     state_nxt = SCAN;
                     col_nxt   = col_rot;
                     cnt_nxt   = '0;
                  end else begin
                     cnt_nxt = cnt_inc;
                  end
               end else begin
                  cnt_nxt = '0;
               end
            end
            default: state_nxt = SCAN;
         endcase
      end
   end

   // A consume and a new accept in the same cycle reload the buffer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_key       <= '0;
         o_key_valid <= 1'b0;
         o_overrun   <= 1'b0;
      end else begin
         o_overrun <= accept && o_key_valid && !i_key_ready;
         if (accept && (!o_key_valid || i_key_ready)) begin
            o_key       <= code;
            o_key_valid <= 1'b1;
         end else if (o_key_valid && i_key_ready) begin
            o_key_valid <= 1'b0;
         end
      end
   end

   assign o_col     = col;
   assign o_pressed = (state == HELD);

endmodule

// File: tb/tb_io_keypad.sv
// Self-checking bench for io_keypad (DIV=4, DEBOUNCE=3): directed table,
// hand-written corner sequences and randomized key activity against a
// behavioural model of the scanner and its output buffer.
module tb_io_keypad;

   localparam int unsigned DIV     = 4;
   localparam int unsigned DEB     = 3;
   localparam int          LAT_MAX = 2 + 4 * DIV + DEB * DIV + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] i_row;
   logic [3:0] o_col;
   logic [3:0] o_key;
   logic       o_key_valid;
   logic       i_key_ready = 1'b0;
   logic       o_pressed;
   logic       o_overrun;

   logic [15:0] keys      = '0;
   logic        force_en  = 1'b0;
   logic [3:0]  force_row = 4'hF;

   int pass_cnt  = 0;
   int total_cnt = 0;
   bit mchk      = 1'b0;

   always #5 clk = ~clk;

   io_keypad #(.DIV(DIV), .DEBOUNCE(DEB)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_row       (i_row),
      .o_col       (o_col),
      .o_key       (o_key),
      .o_key_valid (o_key_valid),
      .i_key_ready (i_key_ready),
      .o_pressed   (o_pressed),
      .o_overrun   (o_overrun)
   );

   // Physical matrix: a pressed key pulls its row low while its column is driven low.
   always_comb begin
      i_row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !o_col[c]) i_row[r] = 1'b0;
      if (force_en) i_row = force_row;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural reference model ----------------
   logic [3:0] m_sync0 = 4'hF, m_sync1 = 4'hF;
   int         m_edges = 0;
   int         m_col   = 0;     // index of the driven column
   int         m_cand  = -1;    // key code being confirmed / held, -1 = none
   int         m_match = 0;
   int         m_rel   = 0;
   bit         m_held  = 1'b0;
   bit         m_over  = 1'b0;
   int         m_buf[$];

   always @(posedge clk or negedge rst) begin
      logic [3:0] s;
      int zeros, zr;
      bit tk, acc;
      if (!rst) begin
         m_sync0 = 4'hF; m_sync1 = 4'hF; m_edges = 0; m_col = 0; m_cand = -1;
         m_match = 0; m_rel = 0; m_held = 1'b0; m_over = 1'b0; m_buf.delete();
      end else begin
         s = m_sync1; m_sync1 = m_sync0; m_sync0 = i_row;
         tk = ((m_edges + 1) % DIV == 0);
         m_edges++;
         acc = 1'b0;
         zeros = 0; zr = 0;
         for (int r = 0; r < 4; r++) if (!s[r]) begin zeros++; zr = r; end
         if (tk) begin
            if (m_held) begin
               if (s == 4'hF) begin
                  m_rel++;
                  if (m_rel == DEB) begin
                     m_held = 1'b0; m_cand = -1; m_rel = 0; m_col = (m_col + 1) % 4;
                  end
               end else m_rel = 0;
            end else if (m_cand < 0) begin
               if (zeros == 1) begin m_cand = zr * 4 + m_col; m_match = 1; end
               else m_col = (m_col + 1) % 4;
            end else begin
               if (zeros == 1 && zr == m_cand / 4) begin
                  m_match++;
                  if (m_match == DEB) begin m_held = 1'b1; m_rel = 0; acc = 1'b1; end
               end else begin
                  m_cand = -1; m_col = (m_col + 1) % 4;
               end
            end
         end
         if (m_buf.size() > 0 && i_key_ready) void'(m_buf.pop_front());
         m_over = 1'b0;
         if (acc) begin
            if (m_buf.size() == 0) m_buf.push_back(m_cand);
            else m_over = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      logic [3:0]  ec, ek;
      logic [10:0] a, e;
      if (mchk) begin
         ec = 4'hF; ec[m_col] = 1'b0;
         ek = (m_buf.size() > 0) ? 4'(m_buf[0]) : 4'h0;
         e  = {ec, m_buf.size() > 0, ek, m_held, m_over};
         a  = {o_col, o_key_valid, o_key_valid ? o_key : 4'h0, o_pressed, o_overrun};
         check("model", a, e);
      end
   end

   // ---------------- helpers ----------------
   task automatic wait_valid(input int budget, output int took, output bit ok);
      ok = 1'b0; took = 0;
      while (took < budget && !ok) begin
         @(negedge clk); took++;
         if (o_key_valid) ok = 1'b1;
      end
   endtask

   task automatic wait_release(input int budget, output int took, output bit ok);
      ok = 1'b0; took = 0;
      while (took < budget && !ok) begin
         @(negedge clk); took++;
         if (!o_pressed) ok = 1'b1;
      end
   endtask

   task automatic watch(input int n, output int vcnt, output int ocnt);
      vcnt = 0; ocnt = 0;
      repeat (n) begin
         @(negedge clk);
         if (o_key_valid) vcnt++;
         if (o_overrun) ocnt++;
      end
   endtask

   typedef struct {
      int         row;
      int         col;
      logic [3:0] exp_key;
   } vec_t;

   initial begin
      vec_t tab[5];
      int   took, vc, oc, n;
      bit   ok;
      logic [3:0] start_col, exp_col, key_at;

      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tab[5];
      int   took, vc, oc, ov_seen;
      bit   ok;
      logic [3:0] start_col, key_at;

      tab[0] = '{1, 2, 4'd6};
      tab[1] = '{0, 0, 4'd0};
      tab[2] = '{3, 3, 4'd15};
      tab[3] = '{2, 1, 4'd9};
      tab[4] = '{0, 3, 4'd3};

      // reset values
      #1 rst = 1'b0;
      mchk = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_col", o_col, 4'b1110);
      check("rst_key", o_key, 4'h0);
      check("rst_valid", o_key_valid, 1'b0);
      check("rst_pressed", o_pressed, 1'b0);
      check("rst_overrun", o_overrun, 1'b0);

      // idle column rotation, DIV clocks per column
      rst = 1'b1;
      vc = 0;
      for (int k = 1; k <= 17; k++) begin
         logic [3:0] ec;
         @(negedge clk);
         ec = 4'hF; ec[(k / DIV) % 4] = 1'b0;
         check("idle_col", o_col, ec);
         if (o_key_valid) vc++;
      end
      check("idle_no_valid", vc, 0);

      // table-driven single presses with an always-ready consumer
      i_key_ready = 1'b1;
      foreach (tab[i]) begin
         keys = 16'(1) << (tab[i].row * 4 + tab[i].col);
         wait_valid(LAT_MAX, took, ok);
         check("press_latency_ok", ok, 1'b1);
         check("press_key", o_key, tab[i].exp_key);
         check("press_pressed", o_pressed, 1'b1);
         @(negedge clk);
         check("valid_one_cycle", o_key_valid, 1'b0);
         keys = '0;
         wait_release(60, took, ok);
         check("release_ok", ok, 1'b1);
         check("release_window", (took >= 3 + (DEB - 1) * DIV) && (took <= 2 + DEB * DIV), 1'b1);
      end

      // glitch: row0 low for exactly one sample tick
      @(negedge clk);
      start_col = o_col;
      force_row = 4'b1110; force_en = 1'b1;
      watch(DIV, vc, oc);
      force_en = 1'b0; force_row = 4'hF;
      begin
         int vc2, oc2;
         watch(11 * DIV, vc2, oc2);
         vc += vc2;
      end
      check("glitch_no_valid", vc, 0);
      check("glitch_col_advances", o_col, {start_col[0], start_col[3:1]});

      // two rows low in the same column are not a key
      @(negedge clk);
      start_col = o_col;
      keys = 16'h0202;
      watch(12 * DIV, vc, oc);
      keys = '0;
      check("tworow_no_valid", vc, 0);
      check("tworow_col_rotates", o_col, start_col);
      repeat (2 * DIV) @(negedge clk);

      // overrun: consumer stalled, second press is dropped
      i_key_ready = 1'b0;
      keys = 16'h0008;
      wait_valid(LAT_MAX, took, ok);
      check("ovr_first_valid", ok, 1'b1);
      check("ovr_first_key", o_key, 4'd3);
      keys = '0;
      wait_release(60, took, ok);
      keys = 16'h0200;
      oc = 0; ov_seen = 0; key_at = 4'hF;
      for (int k = 0; k < LAT_MAX + 10; k++) begin
         @(negedge clk);
         if (o_overrun) begin oc++; key_at = o_key; end
      end
      check("ovr_pulse_count", oc, 1);
      check("ovr_key_kept", key_at, 4'd3);
      check("ovr_still_valid", o_key_valid, 1'b1);
      keys = '0;
      wait_release(60, took, ok);
      check("ovr_key_final", o_key, 4'd3);
      i_key_ready = 1'b1;
      @(negedge clk);
      check("ovr_consumed", o_key_valid, 1'b0);

      // asynchronous reset while a press is being debounced
      keys = 16'h0020;
      took = 0;
      while (took < 40 && !(m_cand >= 0 && !m_held)) begin @(negedge clk); took++; end
      check("rstdb_reached", (m_cand >= 0 && !m_held), 1'b1);
      #1 rst = 1'b0;
      #1;
      check("rstdb_col", o_col, 4'b1110);
      check("rstdb_valid", o_key_valid, 1'b0);
      check("rstdb_pressed", o_pressed, 1'b0);
      check("rstdb_overrun", o_overrun, 1'b0);
      check("rstdb_key", o_key, 4'h0);
      keys = '0;
      @(negedge clk);
      rst = 1'b1;
      watch(10 * DIV, vc, oc);
      check("rstdb_no_valid", vc, 0);

      // randomized key activity and consumer back-pressure
      for (int it = 0; it < 60; it++) begin
         int hold, gap;
         case ($urandom_range(0, 3))
            0:       keys = '0;
            1, 2:    keys = 16'(1) << $urandom_range(0, 15);
            default: keys = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
         endcase
         hold = $urandom_range(DIV, 12 * DIV);
         gap  = $urandom_range(1, 8 * DIV);
         repeat (hold) begin
            @(negedge clk);
            i_key_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 40) == 0) keys = '0;
         end
         keys = '0;
         repeat (gap) begin
            @(negedge clk);
            i_key_ready = ($urandom_range(0, 3) != 0);
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/io_keypad.md
Name: io_keypad

Overview:
Scanner and decoder for a 4x4 passive key matrix; the input-side counterpart of the multiplexed 7-segment display driver. Drives one column low at a time, samples the four row lines, debounces, and encodes a single pressed key to a 4-bit code. The code is delivered through a one-deep valid/ready buffer, so the consumer (e.g. the display digit registers or the ALU front end) can take it at its own pace.

Parameters:
DIV, 1000, clk cycles per column dwell; the row sample tick fires on the last cycle of each dwell; legal range >= 4.
DEBOUNCE, 4, consecutive identical samples of the locked column required to accept a press or a release; legal range 2..15.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-low reset.
i_row  input  4  matrix row lines, active-low (external pull-ups), asynchronous to clk.
o_col  output  4  column drive, active-low, exactly one bit low at all times.
o_key  output  4  key code = row_index*4 + col_index; valid while o_key_valid=1.
o_key_valid  output  1  buffered key available.
i_key_ready  input  1  consumer accepts o_key when high together with o_key_valid.
o_pressed  output  1  level: a debounced key is currently held.
o_overrun  output  1  one-cycle pulse: a new press was accepted while the buffer was still full; that key is dropped.

Behaviour:
- Reset (rst=0, async): o_col=4'b1110, o_key=0, o_key_valid=0, o_pressed=0, o_overrun=0, FSM=SCAN, dwell counter=0, debounce counter=0, synchronizer flops=4'b1111.
- i_row passes through a 2-flop synchronizer; samples use the synchronized value.
- Dwell counter counts 0..DIV-1 and wraps. tick = (count == DIV-1).
- FSM states:
  - SCAN: on tick, if the synchronized row value has exactly one low bit, latch col/row, set debounce counter=1, go to PRESS_DB, and keep the column. Otherwise rotate o_col left (1110 -> 1101 -> 1011 -> 0111 -> 1110). All-high or more than one low bit = no key.
  - PRESS_DB: column frozen. On tick, a sample equal to the latched row increments the counter; any other sample returns to SCAN and rotates the column. When the counter reaches DEBOUNCE: accept the press, set o_pressed=1, go to HELD.
  - HELD: column frozen. On tick, an all-high sample increments the release counter; any other sample resets it to 0. Reaching DEBOUNCE sets o_pressed=0, goes to SCAN, and rotates the column.
- Press acceptance, in the same cycle the FSM enters HELD:
  - If the buffer is empty, or is full but i_key_ready=1 that cycle: load o_key and set o_key_valid=1 on the next edge.
  - If the buffer is full and i_key_ready=0: the buffer is unchanged, and o_overrun pulses for 1 cycle.
- Handshake: when o_key_valid=1 and i_key_ready=1, clear o_key_valid on the next edge unless a simultaneous accept reloads it. o_key is stable while valid.
- Key roll-over is not supported. A second key pressed in HELD is ignored, because only all-high counts toward release.
- Latency: from the i_row change to o_key_valid high is at most 2 sync cycles + 4*DIV (worst-case scan) + DEBOUNCE*DIV + 1.
- A mid-operation reset aborts any state immediately. No key is reported until a fresh full debounce completes.

Decomposition:
- Shared package io_keypad_pkg: FSM state enum (SCAN, PRESS_DB, HELD), COL_INIT = 4'b1110 constant, function onehot_low(row) returning valid flag + 2-bit index.
- One sub-module, keypad_tick: a DIV prescaler with async active-low reset that outputs tick. The FSM, debounce counter and output buffer stay in io_keypad.

Test Plan (DIV=4, DEBOUNCE=3):
- Reset release, no key -> o_col cycles 1110,1101,1011,0111,1110 every 4 clks; o_key_valid stays 0.
- Hold row1 low while col2 is driven, i_key_ready=1 -> o_key=6, o_key_valid is high for exactly 1 cycle, o_pressed=1 until 3 all-high ticks after release.
- Glitch: row0 low for 1 sample tick only -> no valid, FSM back in SCAN, column advances.
- Two rows low in the same column -> treated as no key; no valid.
- i_key_ready=0: press key 3, release, press key 9 -> o_key stays 3, o_overrun pulses once at the second accept, then ready=1 consumes 3 and valid drops.
- Assert rst during PRESS_DB -> all outputs return to reset values asynchronously, and o_col=1110 before the next clk edge.
